// File: rtl/huffman_param_if.sv
// Bus between the pixel-statistics front end, the Huffman encoder and the
// bitstream packer.
//
// Handshake: a sample transfers on a rising clk edge where gray_valid and
// gray_ready are both 1. gray_ready never depends on gray_valid; the source
// may hold gray_valid high while gray_ready is 0 and such cycles transfer
// nothing. CNT_valid and code_valid are single-cycle pulses without
// back-pressure; CNT, HC and M stay stable after their pulse until replaced.
interface huffman_param_if #(
  parameter int NSYM  = 6,
  parameter int CNTW  = 8,
  parameter int CODEW = 8
);
  logic                  gray_valid;
  logic [7:0]            gray_data;
  logic                  gray_ready;
  logic                  CNT_valid;
  logic [NSYM*CNTW-1:0]  CNT;
  logic                  code_valid;
  logic [NSYM*CODEW-1:0] HC;
  logic [NSYM*CODEW-1:0] M;

  modport master (
    output gray_valid, gray_data,
    input  gray_ready, CNT_valid, CNT, code_valid, HC, M
  );

  modport slave (
    input  gray_valid, gray_data,
    output gray_ready, CNT_valid, CNT, code_valid, HC, M
  );
endinterface

// File: rtl/huffman_param.sv
// Frame-based Huffman encoder: counts SAMPLES symbols (1..NSYM), builds a
// deterministic Huffman tree one merge per cycle and publishes right-aligned
// codes and length masks per symbol.
module huffman_param #(
  parameter int NSYM    = 6,
  parameter int CNTW    = 8,
  parameter int SAMPLES = 100,
  parameter int CODEW   = 8
) (
  input  logic           clk,
  input  logic           reset,
  huffman_param_if.slave bus,
  output logic [2:0]     dbg_state
);
  localparam int IDXW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int LENW = $clog2(CODEW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_INIT  = 3'd2,
    S_MERGE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [CNTW-1:0]              smp_q, smp_d;
  logic [NSYM-1:0][CNTW-1:0]    cnt_q, cnt_d;
  // Node storage: a node lives in the slot of its key (smallest member symbol).
  logic [NSYM-1:0][CNTW-1:0]    wt_q, wt_d;
  logic [NSYM-1:0]              live_q, live_d;
  // Per-symbol: slot of the node the symbol currently belongs to.
  logic [NSYM-1:0][IDXW-1:0]    own_q, own_d;
  logic [NSYM-1:0][CODEW-1:0]   code_q, code_d;
  logic [NSYM-1:0][LENW-1:0]    len_q, len_d;
  logic [NSYM-1:0][CODEW-1:0]   hc_q, hc_d;
  logic [NSYM-1:0][CODEW-1:0]   m_q, m_d;
  logic                         cnt_valid_q, cnt_valid_d;
  logic                         code_valid_q, code_valid_d;

  logic                         a_found, b_found;
  logic [IDXW-1:0]              a_idx, b_idx, keep_idx, drop_idx;
  logic                         in_range, accept;
  logic [IDXW-1:0]              sym_idx;

  // Node i merges before node j: lighter first, larger key first on ties.
  function automatic logic precedes(input logic [CNTW-1:0] wi, input int i,
                                    input logic [CNTW-1:0] wj, input int j);
    return (wi < wj) || ((wi == wj) && (i > j));
  endfunction

  assign in_range = (bus.gray_data != 8'd0) && (bus.gray_data <= 8'(NSYM));
  assign accept   = bus.gray_valid && bus.gray_ready && in_range;
  assign sym_idx  = IDXW'(bus.gray_data - 8'd1);

  // Select the two live nodes to merge next (A = first, B = second).
  always_comb begin
    a_found = 1'b0;
    a_idx   = '0;
    b_found = 1'b0;
    b_idx   = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (live_q[i] && (!a_found || precedes(wt_q[i], i, wt_q[a_idx], int'(a_idx)))) begin
        a_found = 1'b1;
        a_idx   = IDXW'(i);
      end
    end
    for (int i = 0; i < NSYM; i++) begin
      if (live_q[i] && (IDXW'(i) != a_idx) &&
          (!b_found || precedes(wt_q[i], i, wt_q[b_idx], int'(b_idx)))) begin
        b_found = 1'b1;
        b_idx   = IDXW'(i);
      end
    end
    keep_idx = (a_idx < b_idx) ? a_idx : b_idx;
    drop_idx = (a_idx < b_idx) ? b_idx : a_idx;
  end

  // Next-state and datapath: counting, tree init, one merge per cycle, publish.
  always_comb begin
    state_d      = state_q;
    smp_d        = smp_q;
    cnt_d        = cnt_q;
    wt_d         = wt_q;
    live_d       = live_q;
    own_d        = own_q;
    code_d       = code_q;
    len_d        = len_q;
    hc_d         = hc_q;
    m_d          = m_q;
    cnt_valid_d  = 1'b0;
    code_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_COUNT: begin
        if (accept) begin
          if (state_q == S_IDLE) begin
            // First sample of a frame wipes the previous frame's counts.
            cnt_d          = '0;
            cnt_d[sym_idx] = CNTW'(1);
            smp_d          = CNTW'(1);
          end else begin
            cnt_d[sym_idx] = cnt_q[sym_idx] + CNTW'(1);
            smp_d          = smp_q + CNTW'(1);
          end
          if (smp_d == CNTW'(SAMPLES)) begin
            state_d     = S_INIT;
            cnt_valid_d = 1'b1;
          end else begin
            state_d = S_COUNT;
          end
        end
      end
      S_INIT: begin
        for (int s = 0; s < NSYM; s++) begin
          wt_d[s]   = cnt_q[s];
          live_d[s] = (cnt_q[s] != '0);
          own_d[s]  = IDXW'(s);
          code_d[s] = '0;
          len_d[s]  = '0;
        end
        state_d = S_MERGE;
      end
      S_MERGE: begin
        if (!b_found) begin
          // Tree complete; a lone leaf keeps len 0 and is published as len 1.
          for (int s = 0; s < NSYM; s++) begin
            hc_d[s] = code_q[s];
            if (cnt_q[s] == '0)       m_d[s] = '0;
            else if (len_q[s] == '0)  m_d[s] = CODEW'(1);
            else                      m_d[s] = ~({CODEW{1'b1}} << len_q[s]);
          end
          code_valid_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          wt_d[keep_idx]   = wt_q[a_idx] + wt_q[b_idx];
          live_d[drop_idx] = 1'b0;
          for (int s = 0; s < NSYM; s++) begin
            if (own_q[s] == a_idx) begin
              code_d[s] = code_q[s] | (CODEW'(1) << len_q[s]);
              len_d[s]  = len_q[s] + LENW'(1);
              own_d[s]  = keep_idx;
            end else if (own_q[s] == b_idx) begin
              len_d[s]  = len_q[s] + LENW'(1);
              own_d[s]  = keep_idx;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      smp_q        <= '0;
      cnt_q        <= '0;
      wt_q         <= '0;
      live_q       <= '0;
      own_q        <= '0;
      code_q       <= '0;
      len_q        <= '0;
      hc_q         <= '0;
      m_q          <= '0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_q        <= smp_d;
      cnt_q        <= cnt_d;
      wt_q         <= wt_d;
      live_q       <= live_d;
      own_q        <= own_d;
      code_q       <= code_d;
      len_q        <= len_d;
      hc_q         <= hc_d;
      m_q          <= m_d;
      cnt_valid_q  <= cnt_valid_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign bus.gray_ready = (state_q == S_IDLE) || (state_q == S_COUNT);
  assign bus.CNT_valid  = cnt_valid_q;
  assign bus.CNT        = cnt_q;
  assign bus.code_valid = code_valid_q;
  assign bus.HC         = hc_q;
  assign bus.M          = m_q;
  assign dbg_state      = state_q;
endmodule

// File: doc/huffman_param.md
# huffman_param

Parametrised Huffman encoder for small-alphabet grey-level streams. It counts a frame of `SAMPLES` symbols, builds a deterministic Huffman tree, and outputs a right-aligned code and length mask for every symbol. The symbol count, count width and code width are parameters. The block also adds input back-pressure, back-to-back frames and exclusion of zero-count symbols. It sits between the pixel-statistics front end and the bitstream packer.

## Interface
- `NSYM`, 6: alphabet size; symbols are 1..NSYM; legal range 2..8.
- `CNTW`, 8: per-symbol count width; `SAMPLES` < 2^CNTW.
- `SAMPLES`, 100: accepted samples per frame.
- `CODEW`, 8: code/mask width per symbol; must be ≥ NSYM-1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets all state immediately.
- `gray_valid` in 1: sample strobe.
- `gray_data` in 8: symbol value.
- `gray_ready` out 1: block accepts samples this cycle.
- `CNT_valid` out 1: one-cycle pulse; `CNT` is final for the frame.
- `CNT` out NSYM*CNTW: count of symbol k in bits [k*CNTW-1 : (k-1)*CNTW].
- `code_valid` out 1: one-cycle pulse; `HC`/`M` are valid.
- `HC` out NSYM*CODEW: code of symbol k, LSB-aligned, same slicing as `CNT`.
- `M` out NSYM*CODEW: mask of symbol k, equal to 2^len-1; 0 if the symbol is absent.

## Operation
- States: IDLE → COUNT → INIT → MERGE (repeats) → DONE → IDLE.
- **Sample acceptance**
  - A sample is accepted when `gray_valid & gray_ready` and `gray_data` is in 1..NSYM.
  - Out-of-range values (0, or >NSYM) are dropped and not counted.
  - `gray_ready` = 1 in IDLE and COUNT, 0 otherwise. Samples presented while `gray_ready`=0 are dropped.
- **IDLE → COUNT**
  - The first accepted sample clears all counts, then counts itself.
  - `CNT` then shows live counts.
- **COUNT**
  - The SAMPLES-th accepted sample completes the frame and the block enters INIT.
  - `CNT_valid` pulses on the following cycle.
  - `CNT` holds its values until the next frame's first accepted sample.
- **INIT**
  - Each symbol with count > 0 becomes a leaf node: weight = count, key = symbol index.
  - Zero-count symbols are excluded and get HC=0, M=0.
  - Working code/length registers are cleared.
- **MERGE, one merge per step**
  - Order live nodes by weight ascending; on equal weight the larger key comes first.
  - A = first node, B = second node.
  - For every symbol in A: code |= 1<<len, then len++. For every symbol in B: code |= 0<<len, then len++.
  - A and B are replaced by one node: weight A+B, key min(keyA, keyB).
  - Repeat until one node remains.
  - Single live leaf: no merge; that symbol gets code 0, len 1.
- **DONE**
  - `HC`/`M` are loaded from the working registers in one cycle; `code_valid` pulses.
  - The block returns to IDLE.
  - `HC`/`M` hold until the next `code_valid`.
- **Arithmetic**
  - Node weights are CNTW bits; a sum never exceeds SAMPLES.
  - len ≤ NSYM-1 ≤ CODEW.

## Timing
- Reset values:
  - `CNT`, `HC`, `M` = 0.
  - `CNT_valid` = 0, `code_valid` = 0, `gray_ready` = 1.
  - State = IDLE.
- Reset is honoured in any state, including mid-COUNT and mid-MERGE. The partial frame is discarded.
- Counting: one accepted sample per cycle, with no bubbles.
- `CNT_valid` comes exactly 1 cycle after the clock edge that accepts the last sample.
- `code_valid` comes ≤ (NSYM-1)*(NSYM+3)+4 cycles after `CNT_valid`. The exact latency is implementation-defined within this bound.
- `gray_ready` is 0 from the `CNT_valid` cycle through the `code_valid` cycle inclusive. It is 1 on the next cycle.
- The next frame may start on the cycle after `code_valid`.

## Test plan
- **Standard frame** (NSYM=6): counts 1:30, 2:25, 3:20, 4:15, 5:6, 6:4.
  - `CNT` matches the counts.
  - HC = 00, 01, 03, 04, 0A, 0B (hex, symbols 1..6).
  - M = 03, 03, 03, 07, 0F, 0F.
- **Single symbol**: 100 samples of value 3 → HC3=00, M3=01; all other HC/M = 0.
- **Tie break**: 50×1 then 50×2 → HC1=0, M1=1; HC2=1, M2=1.
- **Filtering**
  - Values 0 and 7 are interleaved, and gray_valid is held high through busy.
  - Only in-range samples are counted; samples during `gray_ready`=0 are not counted.
  - `CNT_valid` arrives after exactly 100 legal samples.
- **Reset mid-operation**: reset=0 during MERGE → all outputs return to reset values immediately; a new frame then completes correctly.
- **Back-to-back frames**: frame 2 starts the cycle after `code_valid`; `HC`/`M` hold frame-1 values until frame-2 `code_valid`.
